// File: rtl/dram_readout_pkg.sv
// Shared constants, FSM encoding and range helper for the data-memory readout block.
package dram_readout_pkg;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 67001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    // One extra bit on the sum so base+length can never wrap.
    function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] len);
        logic [ADDR_W:0] end_addr;
        end_addr = {1'b0, base} + {1'b0, len};
        return end_addr <= (ADDR_W+1)'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/readout_fifo2.sv
// Two-entry synchronous FIFO; flush empties it without touching stored data.
module readout_fifo2 import dram_readout_pkg::*; #(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot_reg [2];
    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) slot_reg[i] <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                slot_reg[wr_ptr_reg] <= din;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head  = slot_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/dram_readout.sv
// Streams a contiguous byte region from the data memory's external read port
// onto a valid/ready byte link, one byte per clock when the consumer keeps up.
module dram_readout import dram_readout_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    output logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] issued_reg;
    logic [ADDR_W-1:0] sent_reg;
    logic [ADDR_W-1:0] ext_addr_reg;
    logic              inflight_reg;
    logic              err_reg;

    logic [1:0]        fifo_count;
    logic              pop;
    logic              push;
    logic              flush;
    logic              issue;
    logic              last_accept;
    logic              check_go;
    logic [2:0]        occupancy;

    assign tx_valid    = (fifo_count != 2'd0);
    assign pop         = tx_valid && tx_ready;
    assign push        = inflight_reg && (state_reg == STREAM);
    assign flush       = abort && ((state_reg == CHECK) || (state_reg == STREAM));
    assign last_accept = pop && ((sent_reg + ADDR_W'(1)) == len_reg);
    assign check_go    = !abort && (len_reg != '0) && range_ok(base_reg, len_reg);

    // Bytes that will be buffered after this edge; a new fetch needs a free slot then.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue     = (state_reg == STREAM) && !abort && (issued_reg < len_reg)
                       && (occupancy < 3'd2);

    readout_fifo2 #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (ext_data),
        .head  (tx_data),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:   if (start) state_next = CHECK;
            CHECK: begin
                if (abort || (len_reg == '0))        state_next = FINISH;
                else if (!range_ok(base_reg, len_reg)) state_next = IDLE;
                else                                   state_next = STREAM;
            end
            STREAM: if (abort || last_accept) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == CHECK) || (state_reg == STREAM);
        done = (state_reg == FINISH);
        err  = err_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_reg     <= '0;
            len_reg      <= '0;
            issued_reg   <= '0;
            sent_reg     <= '0;
            ext_addr_reg <= '0;
            inflight_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    inflight_reg <= 1'b0;
                    if (start) begin
                        base_reg <= base_addr;
                        len_reg  <= length;
                    end
                end
                CHECK: begin
                    // The first fetch is launched here so data is ready on entry to STREAM.
                    if (check_go) begin
                        ext_addr_reg <= base_reg;
                        issued_reg   <= ADDR_W'(1);
                        sent_reg     <= '0;
                        inflight_reg <= 1'b1;
                    end else if (!abort && (len_reg != '0)) begin
                        err_reg <= 1'b1;
                    end
                end
                STREAM: begin
                    inflight_reg <= issue;
                    if (issue) begin
                        ext_addr_reg <= base_reg + issued_reg;
                        issued_reg   <= issued_reg + ADDR_W'(1);
                    end
                    if (pop) sent_reg <= sent_reg + ADDR_W'(1);
                end
                default: inflight_reg <= 1'b0;
            endcase
        end
    end

    assign ext_addr = ext_addr_reg;

endmodule

// File: tb/tb_dram_readout.sv
// Randomized bench for dram_readout: memory holds mem[a]=a[7:0], expected streams
// are derived arithmetically from base/length.
module tb_dram_readout;
    import dram_readout_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              tx_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]        got_q[$];
    int                acc_cyc_q[$];
    int                done_cnt, err_cnt, done_cyc, valid_seen, stable_viol, va_viol;
    logic [ADDR_W-1:0] max_addr;
    bit                timed_out;

    always #5 clk = ~clk;

    assign ext_data = ext_addr[7:0];

    dram_readout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Drives one start and observes the link until done/err (plus two cycles) or budget.
    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_stream(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                              input int mode, input int abort_after);
        int         accepted = 0;
        int         abort_cyc = -1;
        int         end_cyc = -1;
        int         budget;
        bit         finished = 0;
        logic       prev_v = 1'b0;
        logic       prev_r = 1'b0;
        logic [7:0] prev_d = '0;
        got_q.delete();
        acc_cyc_q.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; valid_seen = 0;
        stable_viol = 0; va_viol = 0; max_addr = '0; timed_out = 0;
        budget = 40 + 4 * int'(l);
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l; tx_ready = 1'b0; abort = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc >= 2 && busy && ext_addr > max_addr) max_addr = ext_addr;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (err) err_cnt++;
            if (tx_valid) valid_seen++;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1 && tx_valid) va_viol++;
            if (abort_cyc < 0 && prev_v && !prev_r && (!tx_valid || tx_data !== prev_d))
                stable_viol++;
            if (end_cyc >= 0 && cyc >= end_cyc + 2) begin
                finished = 1;
                break;
            end
            abort = 1'b0;
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_after >= 0 && abort_cyc < 0 && accepted == abort_after) begin
                abort = 1'b1;
                tx_ready = 1'b0;
                abort_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                acc_cyc_q.push_back(cyc);
                accepted++;
            end
            prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
            if ((done || err) && end_cyc < 0) end_cyc = cyc;
        end
        if (!finished) timed_out = 1;
        tx_ready = 1'b0;
        abort = 1'b0;
        $display("xfer base=%0d len=%0d mode=%0d abort_after=%0d bytes=%0d done=%0d err=%0d",
                 b, l, mode, abort_after, got_q.size(), done_cnt, err_cnt);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ext_addr !== '0) begin n_fail++; $display("FAIL reset_ext_addr: got %0d expected 0", ext_addr); end
        n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL reset_tx_data: got %0d expected 0", tx_data); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_stream(19'd100, 19'd4, 0, -1);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got timeout expected done"); end
        n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            logic [ADDR_W-1:0] a;
            a = 19'd100 + ADDR_W'(i);
            n_checks++; if (got_q[i] !== a[7:0]) begin n_fail++; $display("FAIL basic_byte%0d: got %0d expected %0d", i, got_q[i], a[7:0]); end
        end
        if (acc_cyc_q.size() == 4) begin
            n_checks++; if (acc_cyc_q[3] - acc_cyc_q[0] !== 3) begin n_fail++; $display("FAIL basic_back_to_back: got span %0d expected 3", acc_cyc_q[3] - acc_cyc_q[0]); end
            n_checks++; if (done_cyc !== acc_cyc_q[3] + 1) begin n_fail++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, acc_cyc_q[3] + 1); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (max_addr > 19'd103) begin n_fail++; $display("FAIL basic_addr_bound: got %0d expected <=103", max_addr); end
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_stall;
        run_stream(19'd100, 19'd4, 1, -1);
        n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            logic [ADDR_W-1:0] a;
            a = 19'd100 + ADDR_W'(i);
            n_checks++; if (got_q[i] !== a[7:0]) begin n_fail++; $display("FAIL stall_byte%0d: got %0d expected %0d", i, got_q[i], a[7:0]); end
        end
        n_checks++; if (stable_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stable_viol); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 6; t++) begin
            logic [ADDR_W-1:0] l, b;
            l = ADDR_W'($urandom_range(1, 20));
            b = ADDR_W'($urandom_range(0, MEM_DEPTH - int'(l)));
            run_stream(b, l, 2, -1);
            n_checks++; if (timed_out) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout expected done", t); end
            n_checks++; if (got_q.size() !== int'(l)) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", t, got_q.size(), l); end
            for (int i = 0; i < got_q.size() && i < int'(l); i++) begin
                logic [ADDR_W-1:0] a;
                a = b + ADDR_W'(i);
                n_checks++; if (got_q[i] !== a[7:0]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %0d expected %0d", t, i, got_q[i], a[7:0]); end
            end
            n_checks++; if (stable_viol !== 0) begin n_fail++; $display("FAIL rand%0d_hold: got %0d expected 0", t, stable_viol); end
            n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done_count: got %0d expected 1", t, done_cnt); end
            n_checks++; if (max_addr > b + l - 1) begin n_fail++; $display("FAIL rand%0d_addr_bound: got %0d expected <=%0d", t, max_addr, b + l - 1); end
        end
    endtask

    task automatic test_zero_len;
        run_stream(19'd500, 19'd0, 0, -1);
        n_checks++; if (valid_seen !== 0) begin n_fail++; $display("FAIL zero_valid: got %0d expected 0", valid_seen); end
        n_checks++; if (done_cyc !== 2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 2", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL zero_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_range;
        run_stream(19'd66999, 19'd3, 0, -1);
        n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL range_err: got %0d expected 1", err_cnt); end
        n_checks++; if (valid_seen !== 0) begin n_fail++; $display("FAIL range_valid: got %0d expected 0", valid_seen); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL range_done: got %0d expected 0", done_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL range_busy: got %b expected 0", busy); end
        run_stream(19'd66998, 19'd3, 0, -1);
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL edge_err: got %0d expected 0", err_cnt); end
        n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL edge_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            logic [ADDR_W-1:0] a;
            a = 19'd66998 + ADDR_W'(i);
            n_checks++; if (got_q[i] !== a[7:0]) begin n_fail++; $display("FAIL edge_byte%0d: got %0d expected %0d", i, got_q[i], a[7:0]); end
        end
        n_checks++; if (max_addr > 19'd67000) begin n_fail++; $display("FAIL edge_addr_bound: got %0d expected <=67000", max_addr); end
    endtask

    task automatic test_abort;
        run_stream(19'd0, 19'd10, 0, 3);
        n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL abort_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            n_checks++; if (got_q[i] !== 8'(i)) begin n_fail++; $display("FAIL abort_byte%0d: got %0d expected %0d", i, got_q[i], i); end
        end
        n_checks++; if (va_viol !== 0) begin n_fail++; $display("FAIL abort_valid_drop: got %0d expected 0", va_viol); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt); end
        run_stream(19'd5, 19'd1, 0, -1);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL after_abort_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0] !== 8'd5) begin n_fail++; $display("FAIL after_abort_byte: got %0d expected 5", got_q[0]); end
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        @(negedge clk);
        start = 1'b1; base_addr = 19'd200; length = 19'd50; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_streaming: got %b expected 1", tx_valid); end
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
        n_checks++; if (ext_addr !== '0) begin n_fail++; $display("FAIL midrst_ext_addr: got %0d expected 0", ext_addr); end
        n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL midrst_tx_data: got %0d expected 0", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done || tx_valid || err) bad++;
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done || tx_valid || err) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
        tx_ready = 1'b0;
        $display("xfer reset mid-transfer base=200 len=50 active_after=%0d", bad);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_zero_len();
        test_range();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
